// File: rtl/snapshot_flit_arbiter.sv
// Packet-atomic round-robin arbiter sharing the packetizer snapshot-flit port among NUM_SRC sources.
// Zero-latency mux; a source that sends FIRST keeps the grant until its LAST/SINGLE/NONE.
module snapshot_flit_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 33,
  parameter int SRC_W      = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_SRC*3-1:0]          in_type,
  input  logic [NUM_SRC-1:0]            in_valid,
  output logic [NUM_SRC-1:0]            in_rdy,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [2:0]                    out_type,
  output logic                          out_valid,
  input  logic                          out_rdy,
  output logic [SRC_W-1:0]              out_src,
  output logic                          err_o
);

  localparam logic [2:0] TYPE_NONE   = 3'd0;
  localparam logic [2:0] TYPE_SINGLE = 3'd1;
  localparam logic [2:0] TYPE_FIRST  = 3'd2;
  localparam logic [2:0] TYPE_MIDDLE = 3'd3;
  localparam logic [2:0] TYPE_LAST   = 3'd4;

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] lock_src;
  logic [SRC_W-1:0] grant;
  logic [SRC_W-1:0] scan_idx;
  logic             found;
  logic [SRC_W:0]   cand;
  logic             lock_valid;
  logic             xfer;
  logic [2:0]       eff_type;

  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] x);
    return (x == SRC_W'(NUM_SRC - 1)) ? '0 : x + 1'b1;
  endfunction

  // Round-robin scan starting at rr_ptr; index wraps modulo NUM_SRC, not 2^SRC_W.
  always_comb begin
    found    = 1'b0;
    scan_idx = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand = {1'b0, rr_ptr} + (SRC_W+1)'(i);
      if (cand >= (SRC_W+1)'(NUM_SRC))
        cand = cand - (SRC_W+1)'(NUM_SRC);
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        if (!found && cand == (SRC_W+1)'(k) && in_valid[k]) begin
          found    = 1'b1;
          scan_idx = SRC_W'(k);
        end
      end
    end
  end

  always_comb begin
    lock_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++)
      if (lock_src == SRC_W'(k)) lock_valid = in_valid[k];
  end

  always_comb begin
    grant     = (state == LOCKED) ? lock_src : scan_idx;
    out_valid = (state == LOCKED) ? lock_valid : found;
    out_data  = '0;
    out_type  = TYPE_NONE;
    out_src   = '0;
    in_rdy    = '0;
    if (out_valid) begin
      out_src = grant;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
        if (grant == SRC_W'(k)) begin
          out_data  = in_data[k*DATA_WIDTH +: DATA_WIDTH];
          out_type  = in_type[k*3 +: 3];
          in_rdy[k] = out_rdy;
        end
      end
    end
  end

  assign xfer     = out_valid && out_rdy;
  assign eff_type = (out_type > TYPE_LAST) ? TYPE_NONE : out_type;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      lock_src <= '0;
      err_o    <= 1'b0;
    end else if (xfer) begin
      if (state == IDLE) begin
        if (eff_type == TYPE_FIRST) begin
          state    <= LOCKED;
          lock_src <= grant;
        end else begin
          // An orphan MIDDLE/LAST closes the packet it pretends to belong to.
          rr_ptr <= next_idx(grant);
          if (eff_type == TYPE_MIDDLE || eff_type == TYPE_LAST)
            err_o <= 1'b1;
        end
      end else begin
        if (eff_type == TYPE_FIRST) begin
          err_o <= 1'b1;
        end else if (eff_type != TYPE_MIDDLE) begin
          state  <= IDLE;
          rr_ptr <= next_idx(lock_src);
        end
      end
    end
  end

endmodule
